// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the CPU load/store path owns the port by default, and host bursts fill idle cycles.
// A starvation counter forces a one-cycle CPU stall so that a pending host beat always makes progress.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clka,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_addr,
  input  logic [15:0] cpu_din,
  output logic [15:0] cpu_dout,
  output logic        cpu_stall,
  input  logic        hst_req,
  input  logic        hst_we,
  input  logic [7:0]  hst_addr,
  input  logic [7:0]  hst_len,
  input  logic [15:0] hst_wdata,
  output logic        hst_wready,
  output logic [15:0] hst_rdata,
  output logic        hst_rvalid,
  output logic        hst_done,
  output logic        mem_wea,
  output logic [7:0]  mem_addra,
  output logic [15:0] mem_dina,
  input  logic [15:0] mem_douta
);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic        dir_q, dir_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  rem_q, rem_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [15:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        forced;
  logic        host_slot;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    wait_cnt_d = wait_cnt_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;

    forced    = (state_q == BURST) && (wait_cnt_q == MaxWait);
    host_slot = (state_q == BURST) && (!cpu_en || (wait_cnt_q == MaxWait));

    unique case (state_q)
      IDLE: begin
        if (hst_req) begin
          dir_d      = hst_we;
          addr_d     = hst_addr;
          rem_d      = hst_len;
          wait_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (host_slot) begin
          addr_d     = addr_q + 8'd1;
          rem_d      = rem_q - 8'd1;
          wait_cnt_d = '0;
          if (!dir_q) begin
            rdata_d  = mem_douta;
            rvalid_d = 1'b1;
          end
          if (rem_q == 8'd0) state_d = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs with a memory or handshake side effect are gated by rst so an aborted burst goes quiet at once.
    mem_addra  = host_slot ? addr_q : cpu_addr;
    mem_dina   = host_slot ? hst_wdata : cpu_din;
    mem_wea    = !rst && (host_slot ? dir_q : (cpu_en && cpu_we));
    hst_wready = !rst && host_slot && dir_q;
    cpu_stall  = !rst && forced && cpu_en;
    hst_done   = !rst && (state_q == DONE);
  end

  assign cpu_dout   = mem_douta;
  assign hst_rdata  = rdata_q;
  assign hst_rvalid = rvalid_q;

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q    <= IDLE;
      dir_q      <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      wait_cnt_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      wait_cnt_q <= wait_cnt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a behavioural 256x16 async-read memory sits on the mem_* pins.
module tb_dmem_arbiter;

  logic        clka;
  logic        rst;
  logic        cpu_en;
  logic        cpu_we;
  logic [7:0]  cpu_addr;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        cpu_stall;
  logic        hst_req;
  logic        hst_we;
  logic [7:0]  hst_addr;
  logic [7:0]  hst_len;
  logic [15:0] hst_wdata;
  logic        hst_wready;
  logic [15:0] hst_rdata;
  logic        hst_rvalid;
  logic        hst_done;
  logic        mem_wea;
  logic [7:0]  mem_addra;
  logic [15:0] mem_dina;
  logic [15:0] mem_douta;

  logic [15:0] mem [256];

  int unsigned n_chk;
  int unsigned n_bad;

  dmem_arbiter #(.MAX_WAIT(4)) dut (
    .clka(clka), .rst(rst),
    .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_stall(cpu_stall),
    .hst_req(hst_req), .hst_we(hst_we), .hst_addr(hst_addr), .hst_len(hst_len),
    .hst_wdata(hst_wdata), .hst_wready(hst_wready), .hst_rdata(hst_rdata),
    .hst_rvalid(hst_rvalid), .hst_done(hst_done),
    .mem_wea(mem_wea), .mem_addra(mem_addra), .mem_dina(mem_dina), .mem_douta(mem_douta)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  assign mem_douta = mem[mem_addra];
  always @(posedge clka) if (mem_wea) mem[mem_addra] <= mem_dina;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge; inputs are driven there, outputs checked after #1.
  task automatic step();
    @(posedge clka);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    rst = 1'b1; cpu_en = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_din = 16'h0000;
    hst_req = 1'b0; hst_we = 1'b0; hst_addr = 8'h00; hst_len = 8'h00; hst_wdata = 16'h0000;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_rvalid", 32'(hst_rvalid), 32'd0);
    chk("rst_rdata", 32'(hst_rdata), 32'h0);
    chk("rst_done", 32'(hst_done), 32'd0);
    chk("rst_wready", 32'(hst_wready), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);

    // Uncontended 4-word write at 0x10
    hst_req = 1'b1; hst_we = 1'b1; hst_addr = 8'h10; hst_len = 8'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      hst_req = 1'b0; hst_we = 1'b0; hst_addr = 8'hAA; hst_len = 8'd9;
      hst_wdata = 16'hA000 + 16'(i);
      #1;
      chk("wr_wready", 32'(hst_wready), 32'd1);
      chk("wr_addr", 32'(mem_addra), 32'h10 + 32'(i));
      chk("wr_done_early", 32'(hst_done), 32'd0);
    end
    step(); #1;
    chk("wr_done", 32'(hst_done), 32'd1);
    chk("wr_wready_off", 32'(hst_wready), 32'd0);
    step(); #1;
    chk("wr_done_pulse", 32'(hst_done), 32'd0);
    for (int i = 0; i < 4; i++) chk("wr_mem", 32'(mem[8'h10 + 8'(i)]), 32'hA000 + 32'(i));

    // Uncontended 4-word read of the same words
    hst_req = 1'b1; hst_we = 1'b0; hst_addr = 8'h10; hst_len = 8'd3;
    for (int k = 1; k <= 4; k++) begin
      step();
      hst_req = 1'b0; hst_we = 1'b1;
      #1;
      chk("rd_wea", 32'(mem_wea), 32'd0);
      chk("rd_addr", 32'(mem_addra), 32'h10 + 32'(k - 1));
      chk("rd_rvalid", 32'(hst_rvalid), (k > 1) ? 32'd1 : 32'd0);
      if (k > 1) chk("rd_rdata", 32'(hst_rdata), 32'hA000 + 32'(k - 2));
      chk("rd_done_early", 32'(hst_done), 32'd0);
    end
    step(); #1;
    chk("rd_last_rvalid", 32'(hst_rvalid), 32'd1);
    chk("rd_last_rdata", 32'(hst_rdata), 32'hA003);
    chk("rd_done", 32'(hst_done), 32'd1);
    step(); #1;
    chk("rd_rvalid_off", 32'(hst_rvalid), 32'd0);
    chk("rd_done_off", 32'(hst_done), 32'd0);

    // Contention: CPU stores every cycle, 2-word host write at 0x40; stalls expected in cycles 5 and 10
    hst_req = 1'b1; hst_we = 1'b1; hst_addr = 8'h40; hst_len = 8'd1; hst_wdata = 16'hB000;
    cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h80; cpu_din = 16'hC000;
    for (int k = 1; k <= 11; k++) begin
      step();
      hst_req = 1'b0;
      cpu_addr = 8'h80 + 8'(k);
      cpu_din = 16'hC000 + 16'(k);
      hst_wdata = (k <= 5) ? 16'hB000 : 16'hB001;
      #1;
      if (k <= 10) begin
        chk("ct_stall", 32'(cpu_stall), (k == 5 || k == 10) ? 32'd1 : 32'd0);
        chk("ct_wready", 32'(hst_wready), (k == 5 || k == 10) ? 32'd1 : 32'd0);
      end else begin
        chk("ct_done", 32'(hst_done), 32'd1);
        chk("ct_stall_done", 32'(cpu_stall), 32'd0);
      end
    end
    step();
    cpu_en = 1'b0; cpu_we = 1'b0;
    #1;
    chk("ct_host0", 32'(mem[8'h40]), 32'hB000);
    chk("ct_host1", 32'(mem[8'h41]), 32'hB001);
    chk("ct_cpu_stalled5", 32'(mem[8'h85]), 32'h0);
    chk("ct_cpu_stalled10", 32'(mem[8'h8A]), 32'h0);
    for (int k = 0; k <= 11; k++)
      if (k != 5 && k != 10) chk("ct_cpu_mem", 32'(mem[8'h80 + 8'(k)]), 32'hC000 + 32'(k));

    // Address wrap: 3 words from 0xFE
    hst_req = 1'b1; hst_we = 1'b1; hst_addr = 8'hFE; hst_len = 8'd2;
    for (int i = 0; i < 3; i++) begin
      step();
      hst_req = 1'b0;
      hst_wdata = 16'hD000 + 16'(i);
      #1;
      chk("wrap_addr", 32'(mem_addra), (i == 2) ? 32'h00 : 32'hFE + 32'(i));
    end
    step(); #1;
    chk("wrap_done", 32'(hst_done), 32'd1);
    chk("wrap_fe", 32'(mem[8'hFE]), 32'hD000);
    chk("wrap_ff", 32'(mem[8'hFF]), 32'hD001);
    chk("wrap_00", 32'(mem[8'h00]), 32'hD002);
    step();

    // Reset during the second beat of a 4-beat write at 0x20
    hst_req = 1'b1; hst_we = 1'b1; hst_addr = 8'h20; hst_len = 8'd3;
    step();
    hst_req = 1'b0; hst_wdata = 16'hE000;
    #1;
    chk("ab_beat1", 32'(hst_wready), 32'd1);
    step();
    hst_wdata = 16'hE001; rst = 1'b1;
    #1;
    chk("ab_wea_in_rst", 32'(mem_wea), 32'd0);
    chk("ab_wready_in_rst", 32'(hst_wready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("ab_done", 32'(hst_done), 32'd0);
      chk("ab_wready", 32'(hst_wready), 32'd0);
      chk("ab_rvalid", 32'(hst_rvalid), 32'd0);
      chk("ab_rdata", 32'(hst_rdata), 32'h0);
      chk("ab_stall", 32'(cpu_stall), 32'd0);
      step(); #1;
    end
    chk("ab_mem20", 32'(mem[8'h20]), 32'hE000);
    chk("ab_mem21", 32'(mem[8'h21]), 32'h0);

    // Back-to-back single-word bursts with hst_req held high
    hst_req = 1'b1; hst_we = 1'b1; hst_addr = 8'h30; hst_len = 8'd0; hst_wdata = 16'hF000;
    step(); #1;
    chk("bb_beat1", 32'(hst_wready), 32'd1);
    chk("bb_addr1", 32'(mem_addra), 32'h30);
    step(); #1;
    chk("bb_done1", 32'(hst_done), 32'd1);
    chk("bb_wready_done", 32'(hst_wready), 32'd0);
    step();
    hst_addr = 8'h31; hst_wdata = 16'hF001;
    #1;
    chk("bb_idle", 32'(hst_wready), 32'd0);
    chk("bb_idle_done", 32'(hst_done), 32'd0);
    step();
    hst_req = 1'b0;
    #1;
    chk("bb_beat2", 32'(hst_wready), 32'd1);
    chk("bb_addr2", 32'(mem_addra), 32'h31);
    step(); #1;
    chk("bb_done2", 32'(hst_done), 32'd1);
    step(); #1;
    chk("bb_mem30", 32'(mem[8'h30]), 32'hF000);
    chk("bb_mem31", 32'(mem[8'h31]), 32'hF001);
    chk("bb_quiet", 32'(hst_done), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port 256x16 data memory between the single-cycle CPU datapath and a host/debug burst port. The CPU owns every cycle in which it issues a load/store; host beats fill idle cycles, and a starvation counter forces a one-cycle CPU stall so a pending host burst always progresses. Sits between the CPU load/store path, the host interface and the data memory's wea/addra/dina/douta pins.

## Interface
- MAX_WAIT, 4: consecutive denied host cycles before a forced slot; legal 1..255
- clka  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- cpu_en  in  1  CPU performs a load or store this cycle
- cpu_we  in  1  1 = store, 0 = load; ignored when cpu_en=0
- cpu_addr  in  8  CPU word address
- cpu_din  in  16  CPU store data
- cpu_dout  out  16  load data, = mem_douta (combinational)
- cpu_stall  out  1  CPU must hold PC and architectural state this cycle
- hst_req  in  1  start burst; sampled only in IDLE
- hst_we  in  1  burst direction, 1 = write; latched at start
- hst_addr  in  8  burst start address; latched at start
- hst_len  in  8  beats minus 1 (0 = 1 word, 255 = 256 words); latched at start
- hst_wdata  in  16  write beat data, must be valid throughout write burst
- hst_wready  out  1  write beat consumed at this edge; host advances hst_wdata
- hst_rdata  out  16  registered read data
- hst_rvalid  out  1  hst_rdata holds a valid beat this cycle
- hst_done  out  1  one-cycle pulse, burst complete
- mem_wea  out  1  to data memory write enable
- mem_addra  out  8  to data memory address
- mem_dina  out  16  to data memory write data
- mem_douta  in  16  from data memory, asynchronous read

## Operation
- States: IDLE, BURST, DONE. Registers: dir, addr_q[7:0], rem_q[7:0], wait_cnt[7:0].
- IDLE: hst_req=1 -> latch dir/addr/len into dir/addr_q/rem_q, wait_cnt=0, go BURST. No memory access by host in IDLE.
- BURST: host_slot = (cpu_en==0) or (wait_cnt==MAX_WAIT).
- cpu_stall = BURST and wait_cnt==MAX_WAIT and cpu_en (combinational).
- host_slot: mem_addra=addr_q, mem_dina=hst_wdata, mem_wea=dir; hst_wready=dir; addr_q+=1 mod 256; rem_q-=1; wait_cnt=0; read beats register mem_douta into hst_rdata with hst_rvalid=1 next cycle.
- Not host_slot: wait_cnt+=1; CPU path drives memory.
- Beat with rem_q==0 is last -> DONE. DONE: hst_done=1 for one cycle -> IDLE; CPU owns memory.
- CPU path (all non-host-slot cycles, any state): mem_addra=cpu_addr, mem_dina=cpu_din, mem_wea=cpu_en&cpu_we.
- Address wrap: 0xFF -> 0x00 within a burst, no error.
- hst_req held high through DONE starts a new burst from IDLE on the following cycle.
- Changes to hst_we/hst_addr/hst_len during BURST are ignored.

## Timing
- Reset: state IDLE, wait_cnt 0, hst_rdata 0x0000, hst_rvalid 0, hst_done 0, hst_wready 0, cpu_stall 0. mem_wea forced 0 in any cycle rst=1, so a burst aborted by reset writes nothing further; no hst_done issued for aborted burst.
- Request-to-first-beat: hst_req sampled at edge N (IDLE), first possible beat in cycle N+1.
- Write beat: data written at the edge closing the granted cycle; hst_wready high same cycle.
- Read beat granted in cycle t -> hst_rvalid/hst_rdata in cycle t+1. Last read beat's rvalid coincides with hst_done.
- hst_rvalid is 0 in every cycle not following a read host slot.
- Uncontended burst of L+1 words: L+1 BURST cycles + 1 DONE cycle.
- Worst case: each host beat granted within MAX_WAIT+1 cycles; at most one stall per MAX_WAIT+1 cycles.
- CPU loads always single-cycle when not stalled; stall cycle returns host data on cpu_dout (CPU must discard).

## Test plan
- Uncontended write: cpu_en=0, hst_addr=0x10, hst_len=3, data 0xA000..0xA003 -> wready 4 consecutive cycles, done next cycle; mem[0x10..0x13]=0xA000..0xA003.
- Uncontended read of same 4 words -> rvalid 4 cycles starting one after first grant, rdata 0xA000..0xA003, done with last rvalid.
- Contention: cpu_en=1 continuously, MAX_WAIT=4, 2-word host write -> cpu_stall exactly every 5th cycle, one beat per stall, CPU stores in other cycles land correctly.
- Wrap: hst_addr=0xFE, hst_len=2 write -> words land at 0xFE,0xFF,0x00.
- Reset mid-burst: rst at 2nd beat of 4-beat write -> only beat 1 written, all outputs at reset values, no hst_done.
- Back-to-back: hst_req held high, hst_len=0 -> one beat, done, IDLE, second burst starts next cycle.
